mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 193 +++++++++++++++++++
 tb/tb_mem_access.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Load/store data-bus access unit: lane steering, bus handshake with timeout, load extension.
// Optional build macro MISALIGN_CHECK_EN enables misaligned half/word rejection.
module mem_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] mem_address,
    input  logic [31:0] store_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        resp_valid,
    output logic [31:0] load_data,
    output logic        err
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          req_ready_nxt;
    logic          bus_req_nxt;
    logic          resp_valid_nxt;
    logic          err_nxt;
    logic [31:0]   load_nxt;

    logic          st_q;
    logic [2:0]    f3_q;
    logic [1:0]    lo_q;

    logic          accept_c;
    logic          misalign_c;
    logic [3:0]    be_c;
    logic [31:0]   wdata_c;
    logic [31:0]   rd_ext_c;
    logic [7:0]    rd_byte_c;
    logic [15:0]   rd_half_c;

    assign accept_c = req_valid & req_ready;

`ifdef MISALIGN_CHECK_EN
    assign misalign_c = ((funct3[1:0] == 2'b01) && mem_address[0]) ||
                        (funct3[1] && (mem_address[1:0] != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    // Byte enables and lane-replicated write data derived from the incoming request
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = store_data;
        case (funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << mem_address[1:0];
                wdata_c = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << {mem_address[1], 1'b0};
                wdata_c = {2{store_data[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = store_data;
            end
        endcase
    end

    // Lane select and sign/zero extension of the returned read word
    always_comb begin
        rd_byte_c = bus_rdata[7:0];
        case (lo_q)
            2'd0:    rd_byte_c = bus_rdata[7:0];
            2'd1:    rd_byte_c = bus_rdata[15:8];
            2'd2:    rd_byte_c = bus_rdata[23:16];
            default: rd_byte_c = bus_rdata[31:24];
        endcase
        rd_half_c = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

        rd_ext_c = bus_rdata;
        case (f3_q[1:0])
            2'b00:   rd_ext_c = f3_q[2] ? {24'd0, rd_byte_c} : {{24{rd_byte_c[7]}}, rd_byte_c};
            2'b01:   rd_ext_c = f3_q[2] ? {16'd0, rd_half_c} : {{16{rd_half_c[15]}}, rd_half_c};
            default: rd_ext_c = bus_rdata;
        endcase
        if (st_q) begin
            rd_ext_c = 32'd0;
        end
    end

    // Next-state and next registered-output logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_nxt  = load_data;
        err_nxt   = err;

        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (misalign_c) begin
                        state_nxt = RESP;
                        err_nxt   = 1'b1;
                        load_nxt  = 32'd0;
                    end else begin
                        state_nxt = ACCESS;
                        cnt_nxt   = '0;
                    end
                end
            end
            ACCESS: begin
                if (bus_ack) begin
                    state_nxt = RESP;
                    load_nxt  = rd_ext_c;
                    err_nxt   = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = RESP;
                    load_nxt  = 32'd0;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        req_ready_nxt  = (state_nxt == IDLE);
        bus_req_nxt    = (state_nxt == ACCESS);
        resp_valid_nxt = (state_nxt == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b0;
            bus_req    <= 1'b0;
            resp_valid <= 1'b0;
            load_data  <= 32'd0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            req_ready  <= req_ready_nxt;
            bus_req    <= bus_req_nxt;
            resp_valid <= resp_valid_nxt;
            load_data  <= load_nxt;
            err        <= err_nxt;
        end
    end

    // Request capture; bus fields stay frozen for the whole access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            bus_be    <= 4'd0;
            st_q      <= 1'b0;
            f3_q      <= 3'd0;
            lo_q      <= 2'd0;
        end else if (accept_c) begin
            bus_we    <= is_store;
            bus_addr  <= {mem_address[31:2], 2'b00};
            bus_wdata <= wdata_c;
            bus_be    <= be_c;
            st_q      <= is_store;
            f3_q      <= funct3;
            lo_q      <= mem_address[1:0];
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access (TIMEOUT=4).
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] mem_address;
    logic [31:0] store_data;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        err;

    int checks   = 0;
    int failures = 0;

    mem_access #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .is_store(is_store), .funct3(funct3),
        .mem_address(mem_address), .store_data(store_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .resp_valid(resp_valid), .load_data(load_data), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns just after the accepting edge
    task automatic do_req(input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd);
        @(negedge clk);
        req_valid   = 1'b1;
        is_store    = st;
        funct3      = f3;
        mem_address = a;
        store_data  = sd;
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
    endtask

    // Ack for one cycle; returns at the negedge of the response cycle
    task automatic do_ack(input logic [31:0] rd);
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = rd;
        @(posedge clk);
        #1;
        bus_ack   = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n_req;
        int seen_resp;

        rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        mem_address = 32'd0; store_data = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;

        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Load byte signed, lane 3, ack on first ACCESS cycle
        do_req(1'b0, 3'd0, 32'h0000_1003, 32'd0);
        @(negedge clk);
        check("lb_bus_req", 32'(bus_req), 32'd1);
        check("lb_ready_low", 32'(req_ready), 32'd0);
        check("lb_bus_addr", bus_addr, 32'h0000_1000);
        check("lb_bus_be", 32'(bus_be), 32'h8);
        check("lb_bus_we", 32'(bus_we), 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h80FF_1234;
        @(posedge clk); #1; bus_ack = 1'b0;
        @(negedge clk);
        check("lb_resp_valid", 32'(resp_valid), 32'd1);
        check("lb_bus_req_drop", 32'(bus_req), 32'd0);
        check("lb_load_data", load_data, 32'hFFFF_FF80);
        check("lb_err", 32'(err), 32'd0);
        @(negedge clk);
        check("lb_resp_pulse", 32'(resp_valid), 32'd0);
        check("lb_hold_data", load_data, 32'hFFFF_FF80);
        check("lb_ready_back", 32'(req_ready), 32'd1);

        // Load half unsigned, upper lane, ack after one wait cycle
        do_req(1'b0, 3'd5, 32'h0000_2002, 32'd0);
        @(negedge clk);
        check("lhu_bus_be", 32'(bus_be), 32'hC);
        check("lhu_bus_addr", bus_addr, 32'h0000_2000);
        do_ack(32'h9ABC_5678);
        check("lhu_resp_valid", 32'(resp_valid), 32'd1);
        check("lhu_load_data", load_data, 32'h0000_9ABC);

        // Load byte unsigned lane 1
        do_req(1'b0, 3'd4, 32'h0000_3001, 32'd0);
        @(negedge clk);
        check("lbu_bus_be", 32'(bus_be), 32'h2);
        do_ack(32'h1234_5678);
        check("lbu_load_data", load_data, 32'h0000_0056);

        // Load half signed lower lane
        do_req(1'b0, 3'd1, 32'h0000_4000, 32'd0);
        @(negedge clk);
        check("lh_bus_be", 32'(bus_be), 32'h3);
        do_ack(32'h0000_F00D);
        check("lh_load_data", load_data, 32'hFFFF_F00D);

        // Store half
        do_req(1'b1, 3'd1, 32'h0000_0002, 32'hDEAD_BEEF);
        @(negedge clk);
        check("sh_bus_we", 32'(bus_we), 32'd1);
        check("sh_bus_be", 32'(bus_be), 32'hC);
        check("sh_bus_wdata", bus_wdata, 32'hBEEF_BEEF);
        check("sh_bus_addr", bus_addr, 32'h0000_0000);
        do_ack(32'h5555_AAAA);
        check("sh_resp_valid", 32'(resp_valid), 32'd1);
        check("sh_load_data", load_data, 32'd0);
        check("sh_err", 32'(err), 32'd0);

        // Store byte lane 2
        do_req(1'b1, 3'd0, 32'h0000_5002, 32'h0000_00A5);
        @(negedge clk);
        check("sb_bus_be", 32'(bus_be), 32'h4);
        check("sb_bus_wdata", bus_wdata, 32'hA5A5_A5A5);
        do_ack(32'd0);

        // Ack while idle must be ignored
        @(negedge clk);
        bus_ack = 1'b1;
        @(posedge clk); #1; bus_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_resp", 32'(resp_valid), 32'd0);
        check("idle_ack_ready", 32'(req_ready), 32'd1);
        check("idle_ack_bus_req", 32'(bus_req), 32'd0);

        // Timeout: no ack
        do_req(1'b0, 3'd2, 32'h0000_6000, 32'd0);
        n_req = 0;
        seen_resp = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                seen_resp = 1;
                break;
            end
            if (bus_req) n_req++;
        end
        check("to_resp_seen", 32'(seen_resp), 32'd1);
        check("to_bus_req_cycles", 32'(n_req), 32'd4);
        check("to_err", 32'(err), 32'd1);
        check("to_load_data", load_data, 32'd0);
        @(negedge clk);
        check("to_ready_after", 32'(req_ready), 32'd1);
        check("to_err_hold", 32'(err), 32'd1);

        // Word at a misaligned address
        do_req(1'b0, 3'd2, 32'h0000_0001, 32'd0);
`ifdef MISALIGN_CHECK_EN
        @(negedge clk);
        check("mis_no_bus_req", 32'(bus_req), 32'd0);
        check("mis_resp_valid", 32'(resp_valid), 32'd1);
        check("mis_err", 32'(err), 32'd1);
        check("mis_load_data", load_data, 32'd0);
`else
        @(negedge clk);
        check("mis_bus_req", 32'(bus_req), 32'd1);
        check("mis_bus_addr", bus_addr, 32'h0000_0000);
        check("mis_bus_be", 32'(bus_be), 32'hF);
        do_ack(32'h1122_3344);
        check("mis_resp_valid", 32'(resp_valid), 32'd1);
        check("mis_load_data", load_data, 32'h1122_3344);
        check("mis_err", 32'(err), 32'd0);
`endif

        // Reset pulsed during ACCESS, then a late ack
        @(negedge clk);
        do_req(1'b0, 3'd2, 32'h0000_7000, 32'd0);
        @(negedge clk);
        check("rst_mid_bus_req_hi", 32'(bus_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_bus_req_drop", 32'(bus_req), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd0);
        bus_ack = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1; bus_ack = 1'b0;
        seen_resp = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) seen_resp = 1;
        end
        check("rst_mid_no_resp", 32'(seen_resp), 32'd0);
        check("rst_mid_ready_back", 32'(req_ready), 32'd1);
        check("rst_mid_bus_req_idle", 32'(bus_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
